// File: rtl/k_alu_pkg.sv
// Shared definitions for the k_alu controller: ALU func codes, instruction field
// positions and the issue/writeback FSM state type.
package k_alu_pkg;

   // ALU function codes carried in command[31:28]
   localparam logic [3:0] FUNC_ADD   = 4'd0;
   localparam logic [3:0] FUNC_SUB   = 4'd1;
   localparam logic [3:0] FUNC_MUL   = 4'd2;
   localparam logic [3:0] FUNC_DIV   = 4'd3;
   localparam logic [3:0] FUNC_AND   = 4'd4;
   localparam logic [3:0] FUNC_OR    = 4'd5;
   localparam logic [3:0] FUNC_XOR   = 4'd6;
   localparam logic [3:0] FUNC_NOT   = 4'd7;
   localparam logic [3:0] FUNC_PASSA = 4'd8;
   localparam logic [3:0] FUNC_PASSB = 4'd9;
   localparam logic [3:0] FUNC_SLL   = 4'd10;
   localparam logic [3:0] FUNC_SRL   = 4'd11;
   localparam logic [3:0] FUNC_SRA   = 4'd12;
   localparam logic [3:0] FUNC_INC   = 4'd13;
   localparam logic [3:0] FUNC_DEC   = 4'd14;
   localparam logic [3:0] FUNC_HAMM  = 4'd15;

   // Instruction field bit positions
   localparam int unsigned FUNC_MSB    = 31;
   localparam int unsigned FUNC_LSB    = 28;
   localparam int unsigned USE_IMM_BIT = 27;
   localparam int unsigned RD_MSB      = 26;
   localparam int unsigned RD_LSB      = 24;
   localparam int unsigned RS_MSB      = 22;
   localparam int unsigned RS_LSB      = 20;
   localparam int unsigned RT_MSB      = 18;
   localparam int unsigned RT_LSB      = 16;
   localparam int unsigned IMM_MSB     = 7;
   localparam int unsigned IMM_LSB     = 0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StWb   = 2'd2
   } state_e;

endpackage

// File: rtl/k_regfile8.sv
// 8-entry register file: async reset, one synchronous write port, three
// combinational read ports (two operand reads plus one debug read).
module k_regfile8 #(
   parameter int unsigned NREG = 8,
   parameter int unsigned W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [2:0]   waddr,
   input  logic [W-1:0] wdata,
   input  logic [2:0]   raddr_a,
   output logic [W-1:0] rdata_a,
   input  logic [2:0]   raddr_b,
   output logic [W-1:0] rdata_b,
   input  logic [2:0]   raddr_c,
   output logic [W-1:0] rdata_c
);

   logic [W-1:0] mem_q [NREG];

   // Storage: cleared on reset, written on the rising edge when we is set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];
   assign rdata_c = mem_q[raddr_c];

endmodule

// File: rtl/k_alu_ctrl.sv
// Issue/writeback controller in front of the combinational 8-bit ALU.
// Accepts an instruction in IDLE, drives the ALU command in EXEC, writes the
// captured result back in WB (one instruction per three cycles).
// Optional feature: define K_ALU_CTRL_DIVZ_TRAP_EN to trap divide-by-zero in WB
// (no writeback, err pulse instead of done).
module k_alu_ctrl
   import k_alu_pkg::*;
#(
   parameter int unsigned NREG = 8,
   parameter int unsigned W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  instr,
   output logic [31:0]  command,
   input  logic [W-1:0] alu_res,
   output logic         done,
   output logic         err,
   input  logic [2:0]   dbg_addr,
   output logic [W-1:0] dbg_data
);

   state_e       state_q, state_d;
   logic [31:0]  command_q, command_d;
   logic [2:0]   rd_q, rd_d;
   logic [W-1:0] res_q, res_d;
   logic [W-1:0] rs_data, rt_data;
   logic         in_wb, trap, wb_en;

   // instr[15:8] carries no field; fold it so it is visibly consumed
   logic unused_instr;
   assign unused_instr = ^instr[15:8];

   k_regfile8 #(
      .NREG (NREG),
      .W    (W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_en),
      .waddr   (rd_q),
      .wdata   (res_q),
      .raddr_a (instr[RS_MSB:RS_LSB]),
      .rdata_a (rs_data),
      .raddr_b (instr[RT_MSB:RT_LSB]),
      .rdata_b (rt_data),
      .raddr_c (dbg_addr),
      .rdata_c (dbg_data)
   );

   // State and datapath registers; reset aborts any in-flight instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         command_q <= '0;
         rd_q      <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         command_q <= command_d;
         rd_q      <= rd_d;
         res_q     <= res_d;
      end
   end

   // Next-state: accept in IDLE, capture ALU result in EXEC, write back in WB
   always_comb begin
      state_d   = state_q;
      command_d = command_q;
      rd_d      = rd_q;
      res_d     = res_q;
      in_ready  = 1'b0;
      case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               command_d = {instr[31:16], rs_data,
                            instr[USE_IMM_BIT] ? instr[IMM_MSB:IMM_LSB] : rt_data};
               rd_d      = instr[RD_MSB:RD_LSB];
               state_d   = StExec;
            end
         end
         StExec: begin
            res_d   = alu_res;
            state_d = StWb;
         end
         StWb: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

`ifdef K_ALU_CTRL_DIVZ_TRAP_EN
   assign trap = (command_q[31:28] == FUNC_DIV) && (command_q[7:0] == 8'h00);
`else
   assign trap = 1'b0;
`endif

   assign in_wb   = (state_q == StWb);
   assign wb_en   = in_wb && !trap;
   assign done    = wb_en;
   assign err     = in_wb && trap;
   assign command = command_q;

endmodule
